// File: rtl/unified_mem_arbiter.sv
// Shares one single-port memory between the instruction-fetch and load/store ports.
// Accesses are serialised through IDLE -> BUSY -> RESP with a wait-state timeout.
module unified_mem_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int STARVE_MAX = 4,
   parameter int TIMEOUT    = 15
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  inst_req,
   input  logic [ADDR_WIDTH-1:0] inst_addr,
   output logic [DATA_WIDTH-1:0] inst_rdata,
   output logic                  inst_rdy,
   input  logic                  data_req,
   input  logic                  data_we,
   input  logic [ADDR_WIDTH-1:0] data_addr,
   input  logic [DATA_WIDTH-1:0] data_wdata,
   output logic [DATA_WIDTH-1:0] data_rdata,
   output logic                  data_rdy,
   output logic                  mem_ce,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   input  logic                  mem_ack,
   output logic                  err,
   output logic                  err_src,
   output logic [1:0]            dbg_state
);

   // Handshake: a requester holds req (and its address/data) until its rdy
   // pulses for one cycle; the arbiter never cancels an access once granted.

   localparam int WW = $clog2(TIMEOUT + 1);
   localparam int SW = $clog2(STARVE_MAX + 1);
   localparam logic [WW-1:0]         TIMEOUT_C = WW'(TIMEOUT);
   localparam logic [SW-1:0]         STARVE_C  = SW'(STARVE_MAX);
   localparam logic [DATA_WIDTH-1:0] NOP_INSN  = DATA_WIDTH'(32'h0000_0013);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   state_e                state_q, state_d;
   logic                  owner_q, owner_d;   // 0 = fetch, 1 = data
   logic                  we_q, we_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0] inst_rdata_q, inst_rdata_d;
   logic [DATA_WIDTH-1:0] data_rdata_q, data_rdata_d;
   logic [WW-1:0]         wait_cnt_q, wait_cnt_d;
   logic [SW-1:0]         starve_cnt_q, starve_cnt_d;
   logic                  err_flag_q, err_flag_d;
   logic                  err_src_q, err_src_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         owner_q      <= 1'b0;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         inst_rdata_q <= '0;
         data_rdata_q <= '0;
         wait_cnt_q   <= '0;
         starve_cnt_q <= '0;
         err_flag_q   <= 1'b0;
         err_src_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         inst_rdata_q <= inst_rdata_d;
         data_rdata_q <= data_rdata_d;
         wait_cnt_q   <= wait_cnt_d;
         starve_cnt_q <= starve_cnt_d;
         err_flag_q   <= err_flag_d;
         err_src_q    <= err_src_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      we_d         = we_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      inst_rdata_d = inst_rdata_q;
      data_rdata_d = data_rdata_q;
      wait_cnt_d   = wait_cnt_q;
      starve_cnt_d = starve_cnt_q;
      err_flag_d   = err_flag_q;
      err_src_d    = err_src_q;

      unique case (state_q)
         ST_IDLE: begin
            // Data has priority until it has beaten a waiting fetch STARVE_MAX times.
            if (data_req && (!inst_req || (starve_cnt_q != STARVE_C))) begin
               owner_d = 1'b1;
               we_d    = data_we;
               addr_d  = data_addr;
               wdata_d = data_wdata;
               state_d = ST_BUSY;
               if (inst_req && (starve_cnt_q != STARVE_C)) begin
                  starve_cnt_d = starve_cnt_q + SW'(1);
               end
            end else if (inst_req) begin
               owner_d      = 1'b0;
               we_d         = 1'b0;
               addr_d       = inst_addr;
               wdata_d      = '0;
               state_d      = ST_BUSY;
               starve_cnt_d = '0;
            end
         end
         ST_BUSY: begin
            if (mem_ack) begin
               if (!we_q) begin
                  if (owner_q) data_rdata_d = mem_rdata;
                  else         inst_rdata_d = mem_rdata;
               end
               err_flag_d = 1'b0;
               state_d    = ST_RESP;
            end else begin
               wait_cnt_d = wait_cnt_q + WW'(1);
               if (wait_cnt_d == TIMEOUT_C) begin
                  if (owner_q) data_rdata_d = '0;
                  else         inst_rdata_d = NOP_INSN;
                  err_src_d  = owner_q;
                  err_flag_d = 1'b1;
                  state_d    = ST_RESP;
               end
            end
         end
         ST_RESP: begin
            wait_cnt_d = '0;
            state_d    = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Bus and completion signals are decoded from registered state only.
   assign mem_ce     = (state_q == ST_BUSY);
   assign mem_we     = mem_ce & we_q;
   assign mem_addr   = mem_ce ? addr_q  : '0;
   assign mem_wdata  = mem_ce ? wdata_q : '0;
   assign inst_rdy   = (state_q == ST_RESP) & ~owner_q;
   assign data_rdy   = (state_q == ST_RESP) &  owner_q;
   assign err        = (state_q == ST_RESP) & err_flag_q;
   assign err_src    = err_src_q;
   assign inst_rdata = inst_rdata_q;
   assign data_rdata = data_rdata_q;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: a scoreboard queue holds expected
// {src, err, rdata} responses and a monitor pops one per rdy pulse.
module tb_unified_mem_arbiter;
  localparam int W = 34;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        inst_req = 1'b0;
  logic [31:0] inst_addr = '0;
  logic [31:0] inst_rdata;
  logic        inst_rdy;
  logic        data_req = 1'b0;
  logic        data_we = 1'b0;
  logic [31:0] data_addr = '0;
  logic [31:0] data_wdata = '0;
  logic [31:0] data_rdata;
  logic        data_rdy;
  logic        mem_ce, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack = 1'b0;
  logic        err, err_src;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail = 0;
  logic [W-1:0] exp_q[$];
  int mem_wait = 0;
  bit ack_never = 1'b0;
  bit stray_ack = 1'b0;

  unified_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STARVE_MAX(4), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .inst_rdy(inst_rdy),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_rdata(data_rdata), .data_rdy(data_rdy),
    .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .err(err), .err_src(err_src), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1);
  end

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return (a == 32'h100) ? 32'h0050_0093 : (a ^ 32'h5A5A_0000);
  endfunction

  assign mem_rdata = mem_val(mem_addr);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rsp(input bit src, input bit e, input logic [31:0] d);
    return {src, e, d};
  endfunction

  // ---------------- memory responder ----------------
  initial begin
    int busy_cyc;
    busy_cyc = 0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_ce) begin
        mem_ack = !ack_never && (busy_cyc == mem_wait);
        busy_cyc++;
      end else begin
        busy_cyc = 0;
        mem_ack = stray_ack;
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [W-1:0] e;
    logic [W-1:0] act;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (inst_rdy || data_rdy) begin
          check("single_rdy", {63'b0, inst_rdy & data_rdy}, 64'd0);
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_rdy: got inst_rdy=%0b data_rdy=%0b expected none", inst_rdy, data_rdy);
          end else begin
            e = exp_q.pop_front();
            act = {data_rdy, err, data_rdy ? data_rdata : inst_rdata};
            check("response", {30'b0, act}, {30'b0, e});
            if (e[32]) check("err_src", {63'b0, err_src}, {63'b0, e[33]});
          end
        end else if (err) begin
          n_checks++;
          n_fail++;
          $display("FAIL err_without_rdy: got err=1 expected 0");
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic run_access(input bit is_data, input bit we, input logic [31:0] addr,
                            input logic [31:0] wdata, output int ce_cyc, output int we_cyc,
                            output logic [31:0] last_wdata);
    bit done;
    done = 1'b0;
    ce_cyc = 0;
    we_cyc = 0;
    last_wdata = '0;
    @(posedge clk);
    #1;
    if (is_data) begin
      data_req = 1'b1; data_we = we; data_addr = addr; data_wdata = wdata;
    end else begin
      inst_req = 1'b1; inst_addr = addr;
    end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (mem_ce) begin
        ce_cyc++;
        if (mem_we) we_cyc++;
        last_wdata = mem_wdata;
      end
      if (is_data ? data_rdy : inst_rdy) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL access_timeout: got no rdy expected rdy within 40 cycles (addr %0h)", addr);
    end
    @(posedge clk);
    #1;
    inst_req = 1'b0;
    data_req = 1'b0;
    data_we = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int ce, wc, rdys;
    logic [31:0] lw;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mem_ce", {63'b0, mem_ce}, 64'd0);
    check("rst_inst_rdy", {63'b0, inst_rdy}, 64'd0);
    check("rst_data_rdy", {63'b0, data_rdy}, 64'd0);
    check("rst_err", {63'b0, err}, 64'd0);
    check("rst_err_src", {63'b0, err_src}, 64'd0);
    check("rst_inst_rdata", {32'b0, inst_rdata}, 64'd0);
    check("rst_data_rdata", {32'b0, data_rdata}, 64'd0);
    check("rst_state", {62'b0, dbg_state}, 64'd0);
    rst = 1'b1;

    // single fetch, zero wait
    @(posedge clk);
    #1;
    inst_req = 1'b1;
    inst_addr = 32'h100;
    exp_q.push_back(rsp(1'b0, 1'b0, 32'h0050_0093));
    @(negedge clk);
    check("fetch_T_ce", {63'b0, mem_ce}, 64'd0);
    @(negedge clk);
    check("fetch_T1_ce", {63'b0, mem_ce}, 64'd1);
    check("fetch_T1_addr", {32'b0, mem_addr}, 64'h100);
    check("fetch_T1_we", {63'b0, mem_we}, 64'd0);
    @(negedge clk);
    check("fetch_T2_inst_rdy", {63'b0, inst_rdy}, 64'd1);
    check("fetch_T2_data_rdy", {63'b0, data_rdy}, 64'd0);
    @(posedge clk);
    #1;
    inst_req = 1'b0;
    @(negedge clk);
    check("fetch_T3_idle", {62'b0, dbg_state}, 64'd0);
    check("fetch_T3_rdy_low", {63'b0, inst_rdy}, 64'd0);

    // data load, then store with three wait states
    exp_q.push_back(rsp(1'b1, 1'b0, 32'h5A5A_0300));
    run_access(1'b1, 1'b0, 32'h300, 32'h0, ce, wc, lw);
    check("load_ce_cycles", 64'(ce), 64'd1);
    mem_wait = 3;
    exp_q.push_back(rsp(1'b1, 1'b0, 32'h5A5A_0300));
    run_access(1'b1, 1'b1, 32'h2000, 32'hDEAD_BEEF, ce, wc, lw);
    check("store_ce_cycles", 64'(ce), 64'd4);
    check("store_we_cycles", 64'(wc), 64'd4);
    check("store_wdata", {32'b0, lw}, 64'hDEAD_BEEF);
    mem_wait = 0;

    // simultaneous requests: D,D,D,D,I,D,D,D,D,I
    for (int k = 0; k < 10; k++) begin
      if ((k % 5) == 4) exp_q.push_back(rsp(1'b0, 1'b0, 32'h5A5A_0400));
      else              exp_q.push_back(rsp(1'b1, 1'b0, 32'h5A5A_0500));
    end
    @(posedge clk);
    #1;
    inst_req = 1'b1; inst_addr = 32'h400;
    data_req = 1'b1; data_we = 1'b0; data_addr = 32'h500;
    rdys = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (inst_rdy || data_rdy) rdys++;
      if (rdys == 10) break;
    end
    check("contend_rdy_count", 64'(rdys), 64'd10);
    @(posedge clk);
    #1;
    inst_req = 1'b0;
    data_req = 1'b0;

    // timeout: fetch, then data load
    ack_never = 1'b1;
    exp_q.push_back(rsp(1'b0, 1'b1, 32'h0000_0013));
    run_access(1'b0, 1'b0, 32'h600, 32'h0, ce, wc, lw);
    check("tmo_fetch_ce_cycles", 64'(ce), 64'd15);
    exp_q.push_back(rsp(1'b1, 1'b1, 32'h0));
    run_access(1'b1, 1'b0, 32'h700, 32'h0, ce, wc, lw);
    check("tmo_data_ce_cycles", 64'(ce), 64'd15);
    ack_never = 1'b0;
    @(negedge clk);
    check("err_src_held", {63'b0, err_src}, 64'd1);
    check("err_cleared", {63'b0, err}, 64'd0);

    // stray acks in IDLE and RESP
    stray_ack = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("stray_idle_ce", {63'b0, mem_ce}, 64'd0);
      check("stray_idle_state", {62'b0, dbg_state}, 64'd0);
    end
    exp_q.push_back(rsp(1'b0, 1'b0, 32'h5A5A_0900));
    run_access(1'b0, 1'b0, 32'h900, 32'h0, ce, wc, lw);
    check("stray_fetch_ce_cycles", 64'(ce), 64'd1);
    @(negedge clk);
    check("stray_after_resp_state", {62'b0, dbg_state}, 64'd0);
    repeat (2) @(negedge clk);
    stray_ack = 1'b0;

    // asynchronous reset in the middle of a data access
    mem_wait = 5;
    @(posedge clk);
    #1;
    data_req = 1'b1; data_we = 1'b0; data_addr = 32'h800;
    repeat (3) @(negedge clk);
    check("midrst_busy_ce", {63'b0, mem_ce}, 64'd1);
    #2;
    rst = 1'b0;
    #1;
    check("midrst_ce", {63'b0, mem_ce}, 64'd0);
    check("midrst_mem_addr", {32'b0, mem_addr}, 64'd0);
    check("midrst_data_rdy", {63'b0, data_rdy}, 64'd0);
    check("midrst_err", {63'b0, err}, 64'd0);
    check("midrst_err_src", {63'b0, err_src}, 64'd0);
    check("midrst_inst_rdata", {32'b0, inst_rdata}, 64'd0);
    check("midrst_state", {62'b0, dbg_state}, 64'd0);
    exp_q.push_back(rsp(1'b1, 1'b0, 32'h5A5A_0800));
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    ce = 0;
    rdys = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (mem_ce) ce++;
      if (data_rdy) begin
        rdys = 1;
        break;
      end
    end
    check("postrst_rdy_seen", 64'(rdys), 64'd1);
    check("postrst_ce_cycles", 64'(ce), 64'd6);
    @(posedge clk);
    #1;
    data_req = 1'b0;
    mem_wait = 0;

    repeat (5) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
